// File: rtl/skinny_sbox8_cms1_sched_if.sv
// Bundle of handshake and S-box signals between the CMS1 S-box sequencer and its neighbours.
// The slave modport is the sequencer's own view; master is the surrounding datapath/PRNG/S-box.
interface skinny_sbox8_cms1_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_s0;
  logic [7:0]  in_s1;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [31:0] rnd;
  logic [7:0]  sb_si0;
  logic [7:0]  sb_si1;
  logic [31:0] sb_r;
  logic [7:0]  sb_bo0;
  logic [7:0]  sb_bo1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_s0;
  logic [7:0]  out_s1;
  logic        out_last;
  logic        busy;

  modport slave (
    input  in_valid, in_s0, in_s1, rnd_valid, rnd, sb_bo0, sb_bo1, out_ready,
    output in_ready, rnd_ready, sb_si0, sb_si1, sb_r, out_valid, out_s0, out_s1,
           out_last, busy
  );

  modport master (
    output in_valid, in_s0, in_s1, rnd_valid, rnd, sb_bo0, sb_bo1, out_ready,
    input  in_ready, rnd_ready, sb_si0, sb_si1, sb_r, out_valid, out_s0, out_s1,
           out_last, busy
  );
endinterface

// File: rtl/skinny_sbox8_cms1_sched.sv
// Byte-serial sequencer for a shared 2-share CMS1 SKINNY S-box: latch byte, fetch randomness, hold, capture.
// Optional macro SKINNY_SBOX_ZERO_FLUSH_EN clears the S-box input registers on every capture edge.
module skinny_sbox8_cms1_sched #(
  parameter int SBOX_CYCLES     = 2,
  parameter int BYTES_PER_ROUND = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  skinny_sbox8_cms1_sched_if.slave        bus
);

  localparam int CW = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_ROUND - 1);
  localparam logic [3:0]    EVAL_INIT = 4'(SBOX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RND,
    EVAL,
    OUT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [7:0]      r_si0;
  logic [7:0]      r_si1;
  logic [31:0]     r_r;
  logic [7:0]      r_out_s0;
  logic [7:0]      r_out_s1;
  logic            r_out_last;
  logic [CW-1:0]   r_byte_cnt;
  logic [3:0]      r_eval_cnt;

  logic            w_in_ready;
  logic            w_rnd_ready;
  logic            w_out_valid;
  logic            w_in_fire;
  logic            w_rnd_fire;
  logic            w_capture;
  logic            w_out_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Only the handshake belonging to the current state can fire.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_rnd_ready  = 1'b0;
    w_out_valid  = 1'b0;
    w_in_fire    = 1'b0;
    w_rnd_fire   = 1'b0;
    w_capture    = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_in_fire    = 1'b1;
          w_state_next = RND;
        end
      end
      RND: begin
        w_rnd_ready = 1'b1;
        if (bus.rnd_valid) begin
          w_rnd_fire   = 1'b1;
          w_state_next = EVAL;
        end
      end
      EVAL: begin
        if (r_eval_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = OUT;
        end
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_out_fire   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_si0      <= '0;
      r_si1      <= '0;
      r_r        <= '0;
      r_out_s0   <= '0;
      r_out_s1   <= '0;
      r_out_last <= 1'b0;
      r_byte_cnt <= '0;
      r_eval_cnt <= '0;
    end else begin
      if (w_in_fire) begin
        r_si0 <= bus.in_s0;
        r_si1 <= bus.in_s1;
      end
      if (w_rnd_fire) begin
        r_r        <= bus.rnd;
        r_eval_cnt <= EVAL_INIT;
      end
      if ((r_state == EVAL) && !w_capture) begin
        r_eval_cnt <= r_eval_cnt - 4'd1;
      end
      if (w_capture) begin
        r_out_s0   <= bus.sb_bo0;
        r_out_s1   <= bus.sb_bo1;
        r_out_last <= (r_byte_cnt == LAST_BYTE);
`ifdef SKINNY_SBOX_ZERO_FLUSH_EN
        // Park the S-box on zeros so it never moves directly between two secret-dependent inputs.
        r_si0      <= '0;
        r_si1      <= '0;
        r_r        <= '0;
`endif
      end
      if (w_out_fire) begin
        r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rnd_ready = w_rnd_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = (r_state != IDLE);
  assign bus.sb_si0    = r_si0;
  assign bus.sb_si1    = r_si1;
  assign bus.sb_r      = r_r;
  assign bus.out_s0    = r_out_s0;
  assign bus.out_s1    = r_out_s1;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_skinny_sbox8_cms1_sched.sv
// Self-checking bench for skinny_sbox8_cms1_sched against a transaction/timestamp reference model.
// Honours SKINNY_SBOX_ZERO_FLUSH_EN when predicting the S-box input registers.
module tb_skinny_sbox8_cms1_sched;

  localparam int SBOX_CYCLES     = 2;
  localparam int BYTES_PER_ROUND = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  longint edgeCnt = 0;

  bit          mIdle;
  bit          mWaitRnd;
  bit          mOutPending;
  longint      mCapEdge;
  logic [7:0]  mSi0;
  logic [7:0]  mSi1;
  logic [31:0] mR;
  logic [7:0]  mOut0;
  logic [7:0]  mOut1;
  bit          mLast;
  int          mByteIdx;
  int          lastSeen;

  bit useFixed = 1'b0;

  skinny_sbox8_cms1_sched_if bus ();

  skinny_sbox8_cms1_sched #(
    .SBOX_CYCLES     (SBOX_CYCLES),
    .BYTES_PER_ROUND (BYTES_PER_ROUND)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at edge %0d", tag, observed, expected, edgeCnt);
    end
  endtask

  task automatic modelReset();
    mIdle       = 1'b1;
    mWaitRnd    = 1'b0;
    mOutPending = 1'b0;
    mCapEdge    = -1;
    mSi0        = '0;
    mSi1        = '0;
    mR          = '0;
    mOut0       = '0;
    mOut1       = '0;
    mLast       = 1'b0;
    mByteIdx    = 0;
  endtask

  // Advance the model by one rising edge using the inputs that were stable before it.
  task automatic modelStep();
    if (mIdle) begin
      if (bus.in_valid) begin
        mSi0     = bus.in_s0;
        mSi1     = bus.in_s1;
        mIdle    = 1'b0;
        mWaitRnd = 1'b1;
      end
    end else if (mWaitRnd) begin
      if (bus.rnd_valid) begin
        mR       = bus.rnd;
        mWaitRnd = 1'b0;
        mCapEdge = edgeCnt + SBOX_CYCLES;
      end
    end else if (mOutPending) begin
      if (bus.out_ready) begin
        mByteIdx    = (mByteIdx + 1) % BYTES_PER_ROUND;
        mOutPending = 1'b0;
        mIdle       = 1'b1;
      end
    end else if (edgeCnt == mCapEdge) begin
      mOut0       = bus.sb_bo0;
      mOut1       = bus.sb_bo1;
      mLast       = (mByteIdx == BYTES_PER_ROUND - 1);
      mOutPending = 1'b1;
      if (mLast) lastSeen++;
`ifdef SKINNY_SBOX_ZERO_FLUSH_EN
      mSi0 = '0;
      mSi1 = '0;
      mR   = '0;
`endif
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready",  32'(bus.in_ready),  32'(mIdle));
    checkOutput("rnd_ready", 32'(bus.rnd_ready), 32'(mWaitRnd));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mOutPending));
    checkOutput("busy",      32'(bus.busy),      32'(!mIdle));
    checkOutput("sb_si0",    32'(bus.sb_si0),    32'(mSi0));
    checkOutput("sb_si1",    32'(bus.sb_si1),    32'(mSi1));
    checkOutput("sb_r",      bus.sb_r,           mR);
    checkOutput("out_s0",    32'(bus.out_s0),    32'(mOut0));
    checkOutput("out_s1",    32'(bus.out_s1),    32'(mOut1));
    checkOutput("out_last",  32'(bus.out_last),  32'(mLast));
  endtask

  task automatic driveIdle();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Each cycle: check on the falling edge, drive new inputs, then step the model on the rising edge.
  task automatic applyStimulus(input int cycles, input int pIn, input int pRnd, input int pOut);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkAll();
      bus.in_valid  = ($urandom_range(99) < pIn);
      bus.rnd_valid = ($urandom_range(99) < pRnd);
      bus.out_ready = ($urandom_range(99) < pOut);
      if (useFixed) begin
        bus.in_s0  = 8'h3C;
        bus.in_s1  = 8'hA5;
        bus.rnd    = 32'h12345678;
        bus.sb_bo0 = 8'h11;
        bus.sb_bo1 = 8'h22;
      end else begin
        bus.in_s0  = 8'($urandom);
        bus.in_s1  = 8'($urandom);
        bus.rnd    = $urandom;
        bus.sb_bo0 = 8'($urandom);
        bus.sb_bo1 = 8'($urandom);
      end
      @(posedge clk);
      edgeCnt++;
      modelStep();
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must drop before any edge.
  task automatic pulseReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    driveIdle();
    modelReset();
    #1;
    checkAll();
    #1;
    rst = 1'b0;
    @(posedge clk);
    edgeCnt++;
    modelStep();
  endtask

  initial begin
    int guard;
    driveIdle();
    bus.in_s0  = '0;
    bus.in_s1  = '0;
    bus.rnd    = '0;
    bus.sb_bo0 = '0;
    bus.sb_bo1 = '0;
    lastSeen   = 0;
    modelReset();

    @(negedge clk);
    checkAll();
    #1;
    rst = 1'b0;
    @(posedge clk);
    edgeCnt++;
    modelStep();

    // Directed byte with fixed shares and randomness, consumer stalls the result.
    useFixed = 1'b1;
    applyStimulus(1, 100, 0, 0);
    applyStimulus(1, 0, 100, 0);
    applyStimulus(7, 0, 0, 0);
    applyStimulus(1, 0, 0, 100);
    applyStimulus(3, 0, 0, 0);

    // Randomness withheld for several cycles while sitting in RND.
    useFixed = 1'b0;
    applyStimulus(1, 100, 0, 0);
    applyStimulus(5, 0, 0, 100);
    applyStimulus(1, 0, 100, 100);
    applyStimulus(6, 0, 0, 100);

    // Back-to-back stream long enough to wrap the byte counter, then random traffic.
    applyStimulus(120, 100, 100, 100);
    applyStimulus(1500, 60, 50, 50);
    checkOutput("last_flags_seen", 32'(lastSeen > 1), 32'd1);

    // Abort a byte while it is being evaluated.
    guard = 0;
    while ((mIdle || mWaitRnd || mOutPending) && guard < 200) begin
      applyStimulus(1, 70, 70, 70);
      guard++;
    end
    checkOutput("reach_eval", 32'(guard < 200), 32'd1);
    pulseReset();
    applyStimulus(40, 100, 100, 100);
    applyStimulus(300, 50, 50, 50);

    @(negedge clk);
    checkAll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skinny_sbox8_cms1_sched.md
Name: skinny_sbox8_cms1_sched

Overview:
- Byte-serial sequencer for one shared 2-share CMS1 masked SKINNY 8-bit S-box instance with mixed posedge/negedge internal stages.
- Accepts one masked byte at a time from the round datapath and fetches 32 fresh random bits from the PRNG.
- Holds the S-box inputs and randomness stable for the S-box settling window, then captures the masked result and returns it with valid/ready.
- Counts bytes per round and flags the last byte so the round controller can advance.

Parameters:
- SBOX_CYCLES, 2, full clk cycles inputs are held stable before capture; legal range 1..15.
- BYTES_PER_ROUND, 16, bytes per round; byte counter wraps after BYTES_PER_ROUND-1; legal range 1..256.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  masked byte offered.
- in_ready  output  1  scheduler can accept a byte.
- in_s0  input  8  share 0 of input byte.
- in_s1  input  8  share 1 of input byte.
- rnd_valid  input  1  PRNG word available.
- rnd_ready  output  1  scheduler consumes PRNG word.
- rnd  input  32  fresh randomness.
- sb_si0  output  8  to S-box share-0 input.
- sb_si1  output  8  to S-box share-1 input.
- sb_r  output  32  to S-box refresh mask.
- sb_bo0  input  8  from S-box share-0 output.
- sb_bo1  input  8  from S-box share-1 output.
- out_valid  output  1  masked result valid.
- out_ready  input  1  consumer accepts result.
- out_s0  output  8  result share 0.
- out_s1  output  8  result share 1.
- out_last  output  1  result is byte BYTES_PER_ROUND-1 of the round.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset, asynchronous, immediate: state IDLE; in_ready=1; rnd_ready=0; out_valid=0; out_last=0; busy=0; all data registers, including sb_*, out_s*, byte count and eval count, are 0. Reset mid-operation aborts and discards the current byte and randomness.
- FSM states: IDLE, RND, EVAL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_s0/in_s1 into the sb_si0/sb_si1 registers and go to RND.
- RND:
  - rnd_ready=1.
  - On rnd_valid, latch rnd into the sb_r register, load eval count with SBOX_CYCLES-1, and go to EVAL.
  - Wait indefinitely if rnd_valid stays low.
- EVAL:
  - sb_* registers are held constant.
  - If count≠0, decrement.
  - If count==0, capture sb_bo0/sb_bo1 into out_s0/out_s1, set out_last = (byte count == BYTES_PER_ROUND-1), and go to OUT.
- OUT:
  - out_valid=1; outputs stable until accepted.
  - On out_ready: byte count increments, wrapping to 0 after BYTES_PER_ROUND-1; go to IDLE; out_valid falls next cycle.
- Shares are never combined anywhere in the block. No XOR between shares, and never a share with rnd.
- Latency, with rnd_valid and out_ready held high: in handshake edge E0, rnd handshake at E1, capture at E1+SBOX_CYCLES. out_valid is high in the cycle after the capture edge. Throughput is one byte per SBOX_CYCLES+3 cycles.
- No new byte is accepted until the previous result handshakes: in_ready=0 in RND, EVAL and OUT.
- A randomness word is consumed exactly once per byte, never reused. rnd_ready is never high outside RND.
- in_valid, rnd_valid and out_ready asserted simultaneously: only the handshake matching the current state takes effect.
- SBOX_CYCLES=1: EVAL lasts exactly one cycle.

Optional Feature:
- Macro: SKINNY_SBOX_ZERO_FLUSH_EN.
- Defined: on the capture edge, the sb_si0, sb_si1 and sb_r registers are cleared to 0. The S-box therefore sees all-zero inputs for at least the whole OUT state and IDLE wait before the next byte, so consecutive evaluations never transition directly between secret-dependent values.
- Undefined: the sb_* registers retain their last values until the next latch.

Test Plan:
- Reset then single byte, SBOX_CYCLES=2: in_s0=0x3C, in_s1=0xA5, rnd=0x12345678 one cycle later, S-box model returns bo0=0x11/bo1=0x22 -> out_valid rises 3 edges after the in handshake; out_s0=0x11, out_s1=0x22; in_ready stays 0 until out handshake.
- rnd_valid held low 5 cycles in RND -> FSM stays in RND, sb_r unchanged, out_valid=0; the result appears SBOX_CYCLES+1 edges after rnd_valid rises.
- out_ready low 4 cycles -> out_valid, out_s0 and out_s1 held constant; in_ready=0 throughout; byte count unchanged.
- Stream 17 bytes, BYTES_PER_ROUND=16 -> out_last=1 only on the 16th result; the 17th result has out_last=0 (counter wrapped).
- Assert rst during EVAL -> all outputs return to reset values asynchronously; the next byte completes normally with fresh randomness.
- With SKINNY_SBOX_ZERO_FLUSH_EN -> sb_si0, sb_si1 and sb_r read 0x00/0x00/0x00000000 from the capture edge until the next in handshake. Without it, they retain 0x3C/0xA5/0x12345678.
